// File: rtl/param_stack_unit_if.sv
// Bus bundle for param_stack_unit: operation request in, pop data and stack status out.
interface param_stack_unit_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [1:0]        op;
  logic [DATA_W-1:0] din;
  logic              flush;
  logic              err_clr;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic [DATA_W-1:0] top;
  logic [CNT_W-1:0]  count;
  logic              empty;
  logic              full;
  logic              overflow;
  logic              underflow;

  modport master (
    output op, din, flush, err_clr,
    input  dout, dout_valid, top, count, empty, full, overflow, underflow
  );

  modport slave (
    input  op, din, flush, err_clr,
    output dout, dout_valid, top, count, empty, full, overflow, underflow
  );
endinterface

// File: rtl/param_stack_unit.sv
// Synchronous LIFO stack for CALL/RET and PUSH/POP, with replace, flush
// and sticky overflow/underflow flags. One operation per cycle.
module param_stack_unit #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16
) (
  input logic                clk,
  input logic                rst_n,
  param_stack_unit_if.slave  bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEPTH);

  localparam logic [1:0] OP_NOP     = 2'b00;
  localparam logic [1:0] OP_PUSH    = 2'b01;
  localparam logic [1:0] OP_POP     = 2'b10;
  localparam logic [1:0] OP_REPLACE = 2'b11;

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [CNT_W-1:0]  count_r;
  logic [DATA_W-1:0] dout_r;
  logic              dout_valid_r;
  logic              overflow_r;
  logic              underflow_r;

  logic [CNT_W-1:0]  count_nxt_s;
  logic [DATA_W-1:0] dout_nxt_s;
  logic              dout_valid_nxt_s;
  logic              overflow_nxt_s;
  logic              underflow_nxt_s;
  logic              we_s;
  logic [IDX_W-1:0]  waddr_s;
  logic [IDX_W-1:0]  top_idx_s;
  logic [IDX_W-1:0]  free_idx_s;
  logic              empty_s;
  logic              full_s;

  assign empty_s    = (count_r == CNT_ZERO);
  assign full_s     = (count_r == CNT_MAX);
  // Only meaningful when non-empty / non-full respectively; truncation is safe then.
  assign top_idx_s  = IDX_W'(count_r - CNT_ONE);
  assign free_idx_s = IDX_W'(count_r);

  // Next-state decode: flush overrides op, a new error beats err_clr.
  always_comb begin
    count_nxt_s      = count_r;
    dout_nxt_s       = dout_r;
    dout_valid_nxt_s = 1'b0;
    overflow_nxt_s   = overflow_r & ~bus.err_clr;
    underflow_nxt_s  = underflow_r & ~bus.err_clr;
    we_s             = 1'b0;
    waddr_s          = free_idx_s;
    if (bus.flush) begin
      count_nxt_s = CNT_ZERO;
    end else begin
      case (bus.op)
        OP_PUSH: begin
          if (!full_s) begin
            we_s        = 1'b1;
            waddr_s     = free_idx_s;
            count_nxt_s = count_r + CNT_ONE;
          end else begin
            overflow_nxt_s = 1'b1;
          end
        end
        OP_POP: begin
          if (!empty_s) begin
            dout_nxt_s       = mem_r[top_idx_s];
            dout_valid_nxt_s = 1'b1;
            count_nxt_s      = count_r - CNT_ONE;
          end else begin
            underflow_nxt_s = 1'b1;
          end
        end
        OP_REPLACE: begin
          we_s = 1'b1;
          if (!empty_s) begin
            dout_nxt_s       = mem_r[top_idx_s];
            dout_valid_nxt_s = 1'b1;
            waddr_s          = top_idx_s;
          end else begin
            waddr_s     = {IDX_W{1'b0}};
            count_nxt_s = CNT_ONE;
          end
        end
        OP_NOP: begin
          dout_valid_nxt_s = 1'b0;
        end
        default: begin
          dout_valid_nxt_s = 1'b0;
        end
      endcase
    end
  end

  // Control/status registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_r      <= CNT_ZERO;
      dout_r       <= {DATA_W{1'b0}};
      dout_valid_r <= 1'b0;
      overflow_r   <= 1'b0;
      underflow_r  <= 1'b0;
    end else begin
      count_r      <= count_nxt_s;
      dout_r       <= dout_nxt_s;
      dout_valid_r <= dout_valid_nxt_s;
      overflow_r   <= overflow_nxt_s;
      underflow_r  <= underflow_nxt_s;
    end
  end

  // Storage is never cleared; a write in a reset cycle is dropped.
  always_ff @(posedge clk) begin
    if (rst_n && we_s) begin
      mem_r[waddr_s] <= bus.din;
    end
  end

  assign bus.dout       = dout_r;
  assign bus.dout_valid = dout_valid_r;
  assign bus.top        = empty_s ? {DATA_W{1'b0}} : mem_r[top_idx_s];
  assign bus.count      = count_r;
  assign bus.empty      = empty_s;
  assign bus.full       = full_s;
  assign bus.overflow   = overflow_r;
  assign bus.underflow  = underflow_r;
endmodule

// File: tb/tb_param_stack_unit.sv
// Directed vector table from the test plan, then randomized traffic
// checked against a queue-based stack model.
module tb_param_stack_unit;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  typedef struct {
    logic        rst_n;
    logic [1:0]  op;
    logic [7:0]  din;
    logic        flush;
    logic        err_clr;
    logic [2:0]  cnt;
    logic [7:0]  dout;
    logic        dv;
    logic [7:0]  top;
    logic        ovf;
    logic        unf;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  logic [7:0] mq[$];
  logic [7:0] m_dout;
  logic       m_dv;
  logic       m_ovf;
  logic       m_unf;

  vec_t tbl[$];

  always #5 clk = ~clk;

  param_stack_unit_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  param_stack_unit #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input int e_cnt, input int e_dout,
                           input int e_dv, input int e_top, input int e_ovf, input int e_unf);
    check({tag, " count"}, int'(bus.count), e_cnt);
    check({tag, " dout"}, int'(bus.dout), e_dout);
    check({tag, " dout_valid"}, int'(bus.dout_valid), e_dv);
    check({tag, " top"}, int'(bus.top), e_top);
    check({tag, " empty"}, int'(bus.empty), (e_cnt == 0) ? 1 : 0);
    check({tag, " full"}, int'(bus.full), (e_cnt == DEPTH) ? 1 : 0);
    check({tag, " overflow"}, int'(bus.overflow), e_ovf);
    check({tag, " underflow"}, int'(bus.underflow), e_unf);
  endtask

  // Stack semantics stated directly in terms of a queue whose back is the top.
  task automatic model_step(input logic r, input logic [1:0] o, input logic [7:0] d,
                            input logic f, input logic ec);
    logic new_ovf;
    logic new_unf;
    new_ovf = 1'b0;
    new_unf = 1'b0;
    if (!r) begin
      mq.delete();
      m_dout = 8'h00;
      m_dv   = 1'b0;
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
    end else begin
      m_dv = 1'b0;
      if (f) begin
        mq.delete();
      end else if (o == 2'b01) begin
        if (mq.size() < DEPTH) mq.push_back(d);
        else new_ovf = 1'b1;
      end else if (o == 2'b10) begin
        if (mq.size() > 0) begin
          m_dout = mq.pop_back();
          m_dv   = 1'b1;
        end else begin
          new_unf = 1'b1;
        end
      end else if (o == 2'b11) begin
        if (mq.size() > 0) begin
          m_dout = mq.pop_back();
          m_dv   = 1'b1;
        end
        mq.push_back(d);
      end
      m_ovf = new_ovf | (m_ovf & ~ec);
      m_unf = new_unf | (m_unf & ~ec);
    end
  endtask

  task automatic step(input logic r, input logic [1:0] o, input logic [7:0] d,
                      input logic f, input logic ec);
    @(negedge clk);
    rst_n       = r;
    bus.op      = o;
    bus.din     = d;
    bus.flush   = f;
    bus.err_clr = ec;
    @(posedge clk);
    model_step(r, o, d, f, ec);
    #1;
  endtask

  task automatic add(input logic r, input logic [1:0] o, input logic [7:0] d,
                     input logic f, input logic ec, input logic [2:0] c,
                     input logic [7:0] dout, input logic dv, input logic [7:0] t,
                     input logic ov, input logic un);
    vec_t v;
    v = '{r, o, d, f, ec, c, dout, dv, t, ov, un};
    tbl.push_back(v);
  endtask

  initial begin
    rst_n       = 1'b0;
    bus.op      = 2'b00;
    bus.din     = 8'h00;
    bus.flush   = 1'b0;
    bus.err_clr = 1'b0;

    //   rst  op     din    fl    ec    cnt   dout   dv    top    ovf   unf
    add(1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    add(1'b1, 2'b01, 8'h11, 1'b0, 1'b0, 3'd1, 8'h00, 1'b0, 8'h11, 1'b0, 1'b0);
    add(1'b1, 2'b01, 8'h22, 1'b0, 1'b0, 3'd2, 8'h00, 1'b0, 8'h22, 1'b0, 1'b0);
    add(1'b1, 2'b01, 8'h33, 1'b0, 1'b0, 3'd3, 8'h00, 1'b0, 8'h33, 1'b0, 1'b0);
    add(1'b1, 2'b01, 8'h44, 1'b0, 1'b0, 3'd4, 8'h00, 1'b0, 8'h44, 1'b0, 1'b0);
    add(1'b1, 2'b01, 8'h55, 1'b0, 1'b0, 3'd4, 8'h00, 1'b0, 8'h44, 1'b1, 1'b0);
    add(1'b1, 2'b10, 8'h00, 1'b0, 1'b0, 3'd3, 8'h44, 1'b1, 8'h33, 1'b1, 1'b0);
    add(1'b1, 2'b10, 8'h00, 1'b0, 1'b0, 3'd2, 8'h33, 1'b1, 8'h22, 1'b1, 1'b0);
    add(1'b1, 2'b10, 8'h00, 1'b0, 1'b0, 3'd1, 8'h22, 1'b1, 8'h11, 1'b1, 1'b0);
    add(1'b1, 2'b10, 8'h00, 1'b0, 1'b0, 3'd0, 8'h11, 1'b1, 8'h00, 1'b1, 1'b0);
    add(1'b1, 2'b10, 8'h00, 1'b0, 1'b0, 3'd0, 8'h11, 1'b0, 8'h00, 1'b1, 1'b1);
    add(1'b1, 2'b00, 8'h00, 1'b0, 1'b1, 3'd0, 8'h11, 1'b0, 8'h00, 1'b0, 1'b0);
    add(1'b1, 2'b01, 8'hA0, 1'b0, 1'b0, 3'd1, 8'h11, 1'b0, 8'hA0, 1'b0, 1'b0);
    add(1'b1, 2'b11, 8'hB0, 1'b0, 1'b0, 3'd1, 8'hA0, 1'b1, 8'hB0, 1'b0, 1'b0);
    add(1'b1, 2'b10, 8'h00, 1'b0, 1'b0, 3'd0, 8'hB0, 1'b1, 8'h00, 1'b0, 1'b0);
    add(1'b1, 2'b11, 8'hC0, 1'b0, 1'b0, 3'd1, 8'hB0, 1'b0, 8'hC0, 1'b0, 1'b0);
    add(1'b1, 2'b01, 8'h01, 1'b0, 1'b0, 3'd2, 8'hB0, 1'b0, 8'h01, 1'b0, 1'b0);
    add(1'b1, 2'b01, 8'h02, 1'b0, 1'b0, 3'd3, 8'hB0, 1'b0, 8'h02, 1'b0, 1'b0);
    add(1'b1, 2'b01, 8'h77, 1'b1, 1'b0, 3'd0, 8'hB0, 1'b0, 8'h00, 1'b0, 1'b0);
    add(1'b1, 2'b01, 8'h61, 1'b0, 1'b0, 3'd1, 8'hB0, 1'b0, 8'h61, 1'b0, 1'b0);
    add(1'b1, 2'b01, 8'h62, 1'b0, 1'b0, 3'd2, 8'hB0, 1'b0, 8'h62, 1'b0, 1'b0);
    add(1'b1, 2'b01, 8'h63, 1'b0, 1'b0, 3'd3, 8'hB0, 1'b0, 8'h63, 1'b0, 1'b0);
    add(1'b1, 2'b01, 8'h64, 1'b0, 1'b0, 3'd4, 8'hB0, 1'b0, 8'h64, 1'b0, 1'b0);
    add(1'b1, 2'b01, 8'h65, 1'b0, 1'b0, 3'd4, 8'hB0, 1'b0, 8'h64, 1'b1, 1'b0);
    add(1'b1, 2'b01, 8'h66, 1'b0, 1'b1, 3'd4, 8'hB0, 1'b0, 8'h64, 1'b1, 1'b0);
    add(1'b1, 2'b00, 8'h00, 1'b0, 1'b1, 3'd4, 8'hB0, 1'b0, 8'h64, 1'b0, 1'b0);
    add(1'b1, 2'b11, 8'h99, 1'b0, 1'b0, 3'd4, 8'h64, 1'b1, 8'h99, 1'b0, 1'b0);
    add(1'b1, 2'b10, 8'h00, 1'b0, 1'b0, 3'd3, 8'h99, 1'b1, 8'h63, 1'b0, 1'b0);
    add(1'b1, 2'b01, 8'h13, 1'b1, 1'b0, 3'd0, 8'h99, 1'b0, 8'h00, 1'b0, 1'b0);
    add(1'b1, 2'b01, 8'h21, 1'b0, 1'b0, 3'd1, 8'h99, 1'b0, 8'h21, 1'b0, 1'b0);
    add(1'b1, 2'b01, 8'h22, 1'b0, 1'b0, 3'd2, 8'h99, 1'b0, 8'h22, 1'b0, 1'b0);
    add(1'b0, 2'b10, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    add(1'b1, 2'b10, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1);

    foreach (tbl[i]) begin
      step(tbl[i].rst_n, tbl[i].op, tbl[i].din, tbl[i].flush, tbl[i].err_clr);
      check_all($sformatf("vec%0d", i), int'(tbl[i].cnt), int'(tbl[i].dout),
                int'(tbl[i].dv), int'(tbl[i].top), int'(tbl[i].ovf), int'(tbl[i].unf));
    end

    // Random traffic with occasional flush, err_clr and reset.
    for (int n = 0; n < 600; n++) begin
      logic       r;
      logic [1:0] o;
      logic [7:0] d;
      logic       f;
      logic       ec;
      r  = ($urandom_range(0, 63) != 0);
      o  = 2'($urandom_range(0, 3));
      d  = 8'($urandom);
      f  = ($urandom_range(0, 15) == 0);
      ec = ($urandom_range(0, 7) == 0);
      step(r, o, d, f, ec);
      check_all($sformatf("rnd%0d", n), mq.size(), int'(m_dout), int'(m_dv),
                (mq.size() > 0) ? int'(mq[mq.size()-1]) : 0, int'(m_ovf), int'(m_unf));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/param_stack_unit.md
Name: param_stack_unit

Overview:
- Parameterised, clocked LIFO stack for the pipelined RISC core.
- Serves the CALL/RET return-address path and the PUSH Rd / POP Rd data path.
- Replaces fixed 16-entry, unclocked stack handling with a synchronous block. Adds real occupancy tracking, full/empty status, a same-cycle replace operation, flush, and sticky overflow/underflow error flags.
- Sits in the execute stage; one stack operation per cycle.

Parameters:
DATA_W, 32, width of each stack entry (PC or register value).
DEPTH, 16, number of entries; must be >= 2.
CNT_W, $clog2(DEPTH+1), derived localparam; width of occupancy count. Not overridable.

Ports:
clk  in  1  rising-edge clock.
rst_n  in  1  reset; synchronous, active-low.
op  in  2  operation: 00 NOP, 01 PUSH, 10 POP, 11 REPLACE.
din  in  DATA_W  data to push (return PC or Rd value).
flush  in  1  discard all entries (pipeline redirect / exception).
err_clr  in  1  clear sticky error flags.
dout  out  DATA_W  registered data from the last successful POP/REPLACE.
dout_valid  out  1  one-cycle pulse; dout updated this cycle.
top  out  DATA_W  combinational peek: mem[count-1] when !empty, else 0.
count  out  CNT_W  current occupancy, 0..DEPTH.
empty  out  1  count==0 (combinational from count register).
full  out  1  count==DEPTH (combinational from count register).
overflow  out  1  sticky: PUSH attempted while full.
underflow  out  1  sticky: POP attempted while empty.

Behaviour:
- All state updates occur on rising clk. Priority: rst_n low > flush > op.
- Reset (rst_n=0 at edge):
  - count=0, dout=0, dout_valid=0, overflow=0, underflow=0; hence empty=1, full=0.
  - Storage array is not cleared.
  - A reset mid-sequence discards the in-flight op.
- Stack pointer: count indexes the next free slot; the top entry is mem[count-1]. No wrap-around: count never exceeds DEPTH and never goes below 0.
- PUSH:
  - !full: mem[count]<=din, count<=count+1.
  - full: no write, count held, overflow<=1.
- POP (one-cycle latency):
  - !empty: dout<=mem[count-1], count<=count-1, dout_valid<=1.
  - empty: dout held, dout_valid<=0, underflow<=1.
- REPLACE (RET immediately followed by CALL, or POP+PUSH of Rd):
  - !empty: dout<=old mem[count-1], mem[count-1]<=din, count held, dout_valid<=1. Read returns the pre-write value.
  - empty: acts as PUSH (mem[0]<=din, count<=1), dout_valid<=0, no underflow.
  - Never raises overflow when full.
- NOP: dout_valid<=0; everything else held.
- dout_valid is high for exactly the one cycle after a successful POP/REPLACE edge. dout holds its value otherwise.
- flush=1: count<=0 and dout_valid<=0. op is ignored and no error is raised. dout and the sticky flags are held.
- err_clr=1: overflow<=0 and underflow<=0. If a new error occurs in the same cycle, set wins (flag ends 1).
- top tracks count and memory after each edge. With the same-cycle PUSH, top shows the new value after the edge, not before.

Test Plan:
- DEPTH=4, DATA_W=8. Reset, then PUSH 0x11, 0x22, 0x33, 0x44 -> count=4, full=1, top=0x44. A 5th PUSH 0x55 -> count stays 4, overflow=1, top=0x44.
- From the full state, POP x4 -> dout=0x44, 0x33, 0x22, 0x11 on successive cycles, each with dout_valid=1, ending count=0, empty=1. A 5th POP -> underflow=1, dout stays 0x11, dout_valid=0.
- PUSH 0xA0, then REPLACE din=0xB0 -> next cycle dout=0xA0, dout_valid=1, count=1, top=0xB0. REPLACE on empty with din=0xC0 -> count=1, top=0xC0, dout_valid=0, underflow=0.
- Push 3 entries, then flush=1 together with op=PUSH -> count=0, empty=1, no write, overflow unchanged.
- With overflow=1, assert err_clr together with a PUSH while full -> overflow stays 1. Next cycle, err_clr with op=NOP -> overflow=0.
- Push 2 entries, then assert rst_n=0 for one cycle together with op=POP -> count=0, dout=0, dout_valid=0, flags 0. The following POP -> underflow=1.
